// File: rtl/writeback_queue.sv
// Writeback queue: buffers load/ALU results ahead of the register bank write port
// and forwards the youngest pending value for two read addresses.
module writeback_queue #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned ADDRESS_SIZE  = 5,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [ADDRESS_SIZE-1:0]  mem_addr,
  input  logic [REGISTER_SIZE-1:0] mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [ADDRESS_SIZE-1:0]  alu_addr,
  input  logic [REGISTER_SIZE-1:0] alu_data,
  output logic                     alu_ready,
  input  logic                     stall,
  output logic                     rf_write,
  output logic [ADDRESS_SIZE-1:0]  rf_addr,
  output logic [REGISTER_SIZE-1:0] rf_data,
  input  logic [ADDRESS_SIZE-1:0]  fwd_addr1,
  input  logic [ADDRESS_SIZE-1:0]  fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [REGISTER_SIZE-1:0] fwd_data1,
  output logic [REGISTER_SIZE-1:0] fwd_data2,
  output logic [ADDRESS_SIZE-1:0]  count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [ADDRESS_SIZE-1:0]  addr_q [DEPTH];
  logic [REGISTER_SIZE-1:0] data_q [DEPTH];

  logic                     mem_acc, alu_acc, push, pop;
  logic [ADDRESS_SIZE-1:0]  push_addr;
  logic [REGISTER_SIZE-1:0] push_data;
  logic [PW-1:0]            idx;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = ADDRESS_SIZE'(count_q);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_acc   = mem_valid && mem_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign push_addr = mem_acc ? mem_addr : alu_addr;
  assign push_data = mem_acc ? mem_data : alu_data;
  // Writes to r0 are swallowed: handshake completes but nothing is queued.
  assign push      = (mem_acc || alu_acc) && (push_addr != '0);
  assign pop       = !empty && !stall;

  assign rf_write  = pop;
  assign rf_addr   = empty ? '0 : addr_q[head_q];
  assign rf_data   = empty ? '0 : data_q[head_q];

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (fwd_addr1 != '0 && addr_q[idx] == fwd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if (fwd_addr2 != '0 && addr_q[idx] == fwd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based reference model.
module tb_writeback_queue;

  localparam int unsigned RS = 32;
  localparam int unsigned AS = 5;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid, alu_valid, stall;
  logic [AS-1:0] mem_addr, alu_addr, fwd_addr1, fwd_addr2;
  logic [RS-1:0] mem_data, alu_data;
  logic          mem_ready, alu_ready, rf_write, fwd_hit1, fwd_hit2, full, empty;
  logic [AS-1:0] rf_addr, count;
  logic [RS-1:0] rf_data, fwd_data1, fwd_data2;

  typedef struct {
    logic [AS-1:0] a;
    logic [RS-1:0] d;
  } entry_t;

  entry_t q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_queue #(
    .REGISTER_SIZE(RS),
    .ADDRESS_SIZE (AS),
    .DEPTH        (DP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .alu_valid(alu_valid),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .stall    (stall),
    .rf_write (rf_write),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .fwd_addr1(fwd_addr1),
    .fwd_addr2(fwd_addr2),
    .fwd_hit1 (fwd_hit1),
    .fwd_hit2 (fwd_hit2),
    .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest queued entry with matching non-zero address.
  task automatic model_fwd(input logic [AS-1:0] fa, output logic hit, output logic [RS-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (fa != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == fa) begin
          hit = 1'b1;
          d   = q[i].d;
          break;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst_n, input logic mv, input logic [AS-1:0] ma,
                      input logic [RS-1:0] md, input logic av, input logic [AS-1:0] aa,
                      input logic [RS-1:0] ad, input logic st, input logic [AS-1:0] f1,
                      input logic [AS-1:0] f2);
    logic          e_full, e_mrdy, e_ardy, e_wr, h1, h2;
    logic [RS-1:0] d1, d2;
    entry_t        ne;
    @(negedge clk);
    reset = rst_n; mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad; stall = st;
    fwd_addr1 = f1; fwd_addr2 = f2;
    #1;
    e_full = (q.size() == DP);
    e_mrdy = !e_full;
    e_ardy = !e_full && !mv;
    e_wr   = (q.size() != 0) && !st;
    model_fwd(f1, h1, d1);
    model_fwd(f2, h2, d2);
    check("mem_ready", 64'(mem_ready), 64'(e_mrdy));
    check("alu_ready", 64'(alu_ready), 64'(e_ardy));
    check("full",      64'(full),      64'(e_full));
    check("empty",     64'(empty),     64'(q.size() == 0));
    check("count",     64'(count),     64'(q.size()));
    check("rf_write",  64'(rf_write),  64'(e_wr));
    check("rf_addr",   64'(rf_addr),   (q.size() != 0) ? 64'(q[0].a) : 64'd0);
    check("rf_data",   64'(rf_data),   (q.size() != 0) ? 64'(q[0].d) : 64'd0);
    check("fwd_hit1",  64'(fwd_hit1),  64'(h1));
    check("fwd_data1", 64'(fwd_data1), 64'(d1));
    check("fwd_hit2",  64'(fwd_hit2),  64'(h2));
    check("fwd_data2", 64'(fwd_data2), 64'(d2));
    if (!rst_n) begin
      q.delete();
    end else begin
      if (e_wr) void'(q.pop_front());
      if (mv && e_mrdy) begin
        ne.a = ma; ne.d = md;
        if (ma != '0) q.push_back(ne);
      end else if (av && e_ardy) begin
        ne.a = aa; ne.d = ad;
        if (aa != '0) q.push_back(ne);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic st);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, st, '0, '0);
  endtask

  task automatic alu_push(input logic [AS-1:0] a, input logic [RS-1:0] d, input logic st);
    step(1'b1, 1'b0, '0, '0, 1'b1, a, d, st, '0, '0);
  endtask

  initial begin
    reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0; stall = 1'b0;
    mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0;
    fwd_addr1 = '0; fwd_addr2 = '0;
    @(posedge clk);
    @(posedge clk);

    // Post-reset state, with and without mem_valid pending.
    step(1'b1, 1'b1, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd0);
    idle(1'b0);

    // Single push then drain.
    alu_push(5'd3, 32'hA5A5_A5A5, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Contention: memory wins, ALU retries.
    step(1'b1, 1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd4, 5'd5);
    alu_push(5'd5, 32'h22, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Fill under stall, offer while full, then drain in order.
    for (int i = 1; i <= 4; i++) alu_push(AS'(i), RS'(32'h100 + i), 1'b1);
    step(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd2, 5'd4);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Forwarding picks the youngest of two matches.
    alu_push(5'd7, 32'h1, 1'b1);
    alu_push(5'd7, 32'h2, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Address 0 is consumed but never queued.
    alu_push(5'd0, 32'hFF, 1'b0);
    idle(1'b0);

    // Reset mid-operation discards pending entries and the reset-cycle offer.
    for (int i = 1; i <= 3; i++) alu_push(AS'(i + 10), RS'(i), 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd11, 5'd6);
    idle(1'b0);
    idle(1'b0);

    // Random traffic; small address range to provoke forwarding hits and r0 writes.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 2) == 0), AS'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 1) == 0), AS'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 2) == 0),
           AS'($urandom_range(0, 7)), AS'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter REGISTER_SIZE, default 32, meaning the data width of one register.
REQ-002 The block SHALL have parameter ADDRESS_SIZE, default 5, meaning the register address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset==0 sampled at a rising edge clears state).
REQ-006 mem_valid / mem_addr / mem_data  input  1 / ADDRESS_SIZE / REGISTER_SIZE  load-result producer offer.
REQ-007 mem_ready  output  1  load result accepted this cycle when mem_valid & mem_ready.
REQ-008 alu_valid / alu_addr / alu_data  input  1 / ADDRESS_SIZE / REGISTER_SIZE  ALU-result producer offer.
REQ-009 alu_ready  output  1  ALU result accepted this cycle when alu_valid & alu_ready.
REQ-010 stall  input  1  register bank cannot take a write this cycle.
REQ-011 rf_write / rf_addr / rf_data  output  1 / ADDRESS_SIZE / REGISTER_SIZE  write port into the register bank.
REQ-012 fwd_addr1, fwd_addr2  input  ADDRESS_SIZE each  read addresses to check against pending writes.
REQ-013 fwd_hit1, fwd_hit2  output  1 each  pending write exists for the matching address.
REQ-014 fwd_data1, fwd_data2  output  REGISTER_SIZE each  data of the youngest matching pending write.
REQ-015 count  output  ADDRESS_SIZE  entries held; full and empty  output  1 each  count==DEPTH and count==0.

Function
REQ-016 The queue SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-017 mem_ready SHALL equal !full; alu_ready SHALL equal !full & !mem_valid (memory has priority).
REQ-018 At most one entry SHALL be pushed per cycle: the mem offer if accepted, else the alu offer if accepted.
REQ-019 An accepted offer with address 0 SHALL be consumed (ready honoured) but not enqueued; count unchanged.
REQ-020 rf_write SHALL equal !empty & !stall, combinationally; rf_addr/rf_data SHALL present the head entry whenever !empty, and 0 when empty.
REQ-021 The head entry SHALL be popped at the edge where rf_write==1; no pop while stall==1.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-023 When full, no push SHALL occur even if a pop happens that cycle (ready does not look ahead).
REQ-024 Latency: an entry accepted at edge N into an empty queue SHALL appear on rf_* during cycle N+1.
REQ-025 Forwarding SHALL search all valid entries combinationally; on multiple matches the youngest (closest to tail) SHALL win.
REQ-026 Forwarding SHALL NOT see inputs offered in the current cycle; it covers queued entries only.
REQ-027 fwd_addrX==0 SHALL give fwd_hitX=0 and fwd_dataX=0; any miss SHALL give fwd_dataX=0.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 With reset==0 at an edge: pointers and count SHALL clear, all entries become invalid; next cycle empty=1, full=0, count=0, rf_write=0, rf_addr=0, rf_data=0, fwd_hit1/2=0, mem_ready=1, alu_ready=!mem_valid.
REQ-030 Reset mid-operation SHALL discard pending entries without issuing their writes; offers in the reset cycle SHALL be dropped.
REQ-031 Entry storage contents need not clear; only validity state is required to reset.

Verification
REQ-032 Single push: alu_valid=1, addr=3, data=0xA5A5A5A5 one cycle, stall=0 -> next cycle rf_write=1, rf_addr=3, rf_data=0xA5A5A5A5, then empty=1.
REQ-033 Contention: mem(addr 4, 0x11) and alu(addr 5, 0x22) valid together -> mem_ready=1, alu_ready=0; mem written first, alu written after retry.
REQ-034 Fill under stall: stall=1, push addrs 1,2,3,4 (DEPTH=4) -> full=1, count=4, both ready=0; release stall -> four writes in order 1,2,3,4 on consecutive cycles.
REQ-035 Forwarding: queue holds addr 7=0x1 then addr 7=0x2, stall=1, fwd_addr1=7, fwd_addr2=0 -> fwd_hit1=1, fwd_data1=0x2, fwd_hit2=0, fwd_data2=0.
REQ-036 Address 0: alu_valid, addr=0, data=0xFF -> alu_ready=1, count stays 0, no rf_write.
REQ-037 Reset mid-op: count=3 under stall, reset=0 one edge -> count=0, empty=1, no writes issued after stall released.
